starship_combo_arbiter: RTL
===========================

# starship_combo_arbiter

Arbiter and sequencer that hands out 4-bit hex repair combinations to the four repair state machines (top, bottom, left, right). It shares the single `random_hex` source from the PRNG between them. It scrambles each sample with a local LFSR, checks it against combinations already in use, and grants a unique combo to one requester at a time in round-robin order. It sits between the PRNG and the four repair SMs in the top level and runs on `board_clk`.

## Interface
Parameters:
- `RETRY_MAX`, default 3: maximum number of samples drawn per grant (≥1) before the fallback value is used.

Ports:
- `board_clk`  in  1  system clock, 100 MHz.
- `Reset`  in  1  reset Reset, asynchronous, active-high; clock board_clk.
- `play_flag`  in  1  game in Play state; new arbitration starts only while high.
- `gameover_ctrl`  in  1  game over; aborts arbitration and frees all combos.
- `req`  in  4  level requests. Bit 0 top, 1 bottom, 2 left, 3 right. Each is held by its requester until `gnt`.
- `release`  in  4  one-cycle pulse per station when its repair completes; frees that station's combo.
- `random_hex`  in  4  shared PRNG output, sampled asynchronously to its slow clock.
- `gnt`  out  4  one-hot, one-cycle grant pulse.
- `combo_out`  out  4  granted combo, valid while `gnt` is nonzero.
- `combo_bus`  out  16  per-station combo register; bits [4i+3:4i] belong to station i.
- `active`  out  4  station holds a live combo.
- `busy`  out  1  FSM is not in IDLE.

## Operation
- Reset values: `gnt`=0, `combo_out`=0, `combo_bus`=0, `active`=0, `busy`=0. Internal: round-robin pointer `rr`=0, `lfsr`=4'b1001, `tries`=0.
- Eligible requesters are `req[i] & ~active[i]`. Requests from stations that are already active are ignored.
- FSM states are IDLE, SAMPLE, CHECK and GRANT.
- IDLE:
  - Moves to SAMPLE when `play_flag` is high, `gameover_ctrl` is low and any requester is eligible.
  - Latches `sel`, the first eligible station searching from `rr` upward and wrapping 3→0.
  - Clears `tries`.
- SAMPLE:
  - `cand <= random_hex ^ lfsr` and `tries <= tries+1`.
  - The LFSR advances only here: `lfsr <= {lfsr[2:0], lfsr[3]^lfsr[2]}`. The sequence is 9, 3, 6, D, A, ….
  - Moves to CHECK.
- CHECK: a collision means `cand` equals `combo_bus` slot j for some j≠sel with `active[j]`.
  - No collision: go to GRANT.
  - Collision and `tries < RETRY_MAX`: go back to SAMPLE.
  - Collision and `tries == RETRY_MAX`: set `cand` to the lowest value in 0..F not held by any active station, then go to GRANT. A free value always exists because at most 3 are held.
- GRANT:
  - `gnt[sel]`=1 and `combo_out`=`cand` for this cycle only.
  - `combo_bus[sel] <= cand`, `active[sel] <= 1`, `rr <= sel+1` (mod 4).
  - Moves to IDLE.
- `release[i]` clears `active[i]` on the next edge in any state. `combo_bus` keeps its stale value.
  - If `release[j]` coincides with CHECK, the comparison uses the pre-edge `active`.
  - If `release[sel]` coincides with GRANT, the grant wins.
- `gameover_ctrl` high, in any state:
  - FSM goes to IDLE on the next edge and `active` is cleared to 0.
  - No `gnt` is issued that cycle.
  - `rr` and `lfsr` are preserved.
- `play_flag` falling mid-operation: an in-flight grant completes, and no new arbitration starts.
- Asynchronous `Reset` mid-operation returns everything to reset values immediately. No `gnt` pulse follows.

## Timing
- `req` sampled eligible at edge k (FSM in IDLE): SAMPLE in cycle k+1, CHECK in k+2, `gnt` high during k+3.
- Each retry adds 2 cycles. The fallback adds 0 cycles.
- Back-to-back grants are spaced 4 cycles apart: GRANT, IDLE, SAMPLE, CHECK.
- `active` and `combo_bus` update at the edge ending the GRANT cycle.
- `busy` is a registered decode of state ≠ IDLE.

## Configuration
- `STARSHIP_COMBO_UNIQUE_EN`:
  - Defined: CHECK performs the collision, retry and fallback logic described above.
  - Undefined: CHECK always proceeds to GRANT with the raw sample. Duplicates are allowed, latency is fixed at 3 cycles, `RETRY_MAX` is unused and the fallback logic is not synthesized.

## Test plan
- Single grant: reset, `play_flag`=1, `random_hex`=0, `req`=0001 → `gnt`=0001 exactly 3 cycles after `req` sampled, `combo_out`=9, `active`=0001.
- Collision retry (macro defined): after the single-grant test, hold `random_hex`=A and set `req`=0010. First sample is A^3=9 and collides; second is A^6=C → `gnt`=0010 at 5 cycles, `combo_bus[7:4]`=C.
- Fallback: `RETRY_MAX`=1, station 0 active with 9, `random_hex`=A, `req`=0010 → `gnt`=0010 at 3 cycles, `combo_out`=0.
- Round-robin: after reset, `random_hex`=0, `req`=1111 held → grants 0001, 0010, 0100, 1000, each 4 cycles apart, with combos 9, 3, 6, D.
- Release and re-request: station 0 active, pulse `release`=0001 → `active[0]`=0 next cycle, and a subsequent `req[0]` is granted again.
- Abort: assert `gameover_ctrl` during CHECK → no `gnt`, FSM back in IDLE, `active`=0, `busy`=0 next cycle.

Source files
------------

// File: rtl/starship_combo_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | starship_combo_arbiter_if                                                  |
// | Request/grant bundle between the repair SMs and the combo arbiter.         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface starship_combo_arbiter_if;
    logic        play_flag;
    logic        gameover_ctrl;
    logic [3:0]  req;
    logic [3:0]  release_stn;
    logic [3:0]  random_hex;
    logic [3:0]  gnt;
    logic [3:0]  combo_out;
    logic [15:0] combo_bus;
    logic [3:0]  active;
    logic        busy;

    // Requester / game-control side.
    modport master (
        output play_flag, gameover_ctrl, req, release_stn, random_hex,
        input  gnt, combo_out, combo_bus, active, busy
    );

    // Arbiter side.
    modport slave (
        input  play_flag, gameover_ctrl, req, release_stn, random_hex,
        output gnt, combo_out, combo_bus, active, busy
    );
endinterface
`default_nettype wire

// File: rtl/starship_combo_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | starship_combo_arbiter                                                     |
// | Round-robin hand-out of scrambled 4-bit repair combos to four stations.    |
// | STARSHIP_COMBO_UNIQUE_EN enables collision check, retry and fallback.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module starship_combo_arbiter #(
    parameter int RETRY_MAX = 3
) (
    input  logic                     board_clk,
    input  logic                     Reset,
    starship_combo_arbiter_if.slave  arb
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        CHECK  = 2'd2,
        GRANT  = 2'd3
    } state_t;

    localparam logic [3:0] LFSR_SEED = 4'b1001;

    state_t      state, state_nxt;
    logic [1:0]  rr, sel, sel_nxt, idx;
    logic [3:0]  lfsr, cand, active, eligible, sel_onehot;
    logic [3:0]  gnt, combo_out, fallback;
    logic [15:0] combo_bus;
    logic        busy, start, grant_fire, retry, fb_take;

    assign eligible   = arb.req & ~active;
    assign start      = arb.play_flag & ~arb.gameover_ctrl & (|eligible);
    assign grant_fire = (state == GRANT) & ~arb.gameover_ctrl;
    assign sel_onehot = 4'b0001 << sel;

    // First eligible station at or above rr, wrapping; lowest offset wins.
    always_comb begin
        sel_nxt = rr;
        idx     = rr;
        for (int k = 3; k >= 0; k--) begin
            idx = rr + 2'(k);
            if (eligible[idx]) sel_nxt = idx;
        end
    end

`ifdef STARSHIP_COMBO_UNIQUE_EN
    localparam int                 TRIES_W     = $clog2(RETRY_MAX + 1);
    localparam logic [TRIES_W-1:0] TRIES_LIMIT = TRIES_W'(RETRY_MAX);

    logic [TRIES_W-1:0] tries;
    logic               collide, held;

    always_comb begin
        collide = 1'b0;
        for (int j = 0; j < 4; j++)
            if (active[j] && (2'(j) != sel) && (combo_bus[4*j +: 4] == cand))
                collide = 1'b1;
        fallback = 4'd0;
        held     = 1'b0;
        for (int v = 15; v >= 0; v--) begin
            held = 1'b0;
            for (int j = 0; j < 4; j++)
                if (active[j] && (combo_bus[4*j +: 4] == 4'(v)))
                    held = 1'b1;
            if (!held) fallback = 4'(v);
        end
    end

    assign retry   = collide & (tries < TRIES_LIMIT);
    assign fb_take = (state == CHECK) & collide & (tries >= TRIES_LIMIT);

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset)                tries <= '0;
        else if (state == IDLE)   tries <= '0;
        else if (state == SAMPLE) tries <= tries + 1'b1;
    end
`else
    assign retry    = 1'b0;
    assign fb_take  = 1'b0;
    assign fallback = 4'd0;
`endif

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        gnt       = 4'd0;
        combo_out = 4'd0;
        case (state)
            IDLE:    if (start) state_nxt = SAMPLE;
            SAMPLE:  state_nxt = CHECK;
            CHECK:   state_nxt = retry ? SAMPLE : GRANT;
            GRANT:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (arb.gameover_ctrl) state_nxt = IDLE;
        if (grant_fire) begin
            gnt       = sel_onehot;
            combo_out = cand;
        end
    end

    // random_hex is pure entropy, so a metastable-resolved value is as good as any.
    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            rr        <= 2'd0;
            sel       <= 2'd0;
            lfsr      <= LFSR_SEED;
            cand      <= 4'd0;
            combo_bus <= 16'd0;
            active    <= 4'd0;
            busy      <= 1'b0;
        end else begin
            busy <= (state_nxt != IDLE);
            if ((state == IDLE) && start) sel <= sel_nxt;
            if (state == SAMPLE) begin
                cand <= arb.random_hex ^ lfsr;
                lfsr <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
            end
            if (fb_take) cand <= fallback;
            if (arb.gameover_ctrl) begin
                active <= 4'd0;
            end else if (grant_fire) begin
                active                <= (active & ~arb.release_stn) | sel_onehot;
                combo_bus[4*sel +: 4] <= cand;
                rr                    <= sel + 2'd1;
            end else begin
                active <= active & ~arb.release_stn;
            end
        end
    end

    assign arb.gnt       = gnt;
    assign arb.combo_out = combo_out;
    assign arb.combo_bus = combo_bus;
    assign arb.active    = active;
    assign arb.busy      = busy;
endmodule
`default_nettype wire
